// File: rtl/aes_ram_sequencer_pkg.sv
// Shared definitions for the AES RAM sequencer: phase encodings and idle RAM-port value.
package aes_ram_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_H1    = 3'd2,
        ST_ENC   = 3'd3,
        ST_H2    = 3'd4,
        ST_DEC   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } state_e;

    // Every RAM output bit takes this value whenever no engine owns the ports.
    localparam logic RAM_IDLE_BIT = 1'b0;

    function automatic logic is_engine_phase(input state_e s);
        return (s == ST_INIT) || (s == ST_ENC) || (s == ST_DEC);
    endfunction

    function automatic logic is_busy_state(input state_e s);
        return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERROR);
    endfunction

endpackage

// File: rtl/aes_ram_sequencer_if.sv
// Engine, RAM and status signals of the AES RAM sequencer.
interface aes_ram_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  timeout_err;
    logic [2:0]            phase;

    logic                  init_ena;
    logic                  init_finished;
    logic [ADDR_WIDTH-1:0] init_addrA;
    logic [ADDR_WIDTH-1:0] init_addrB;
    logic                  init_wr_enaA;
    logic                  init_wr_enaB;
    logic [DATA_WIDTH-1:0] init_dataA;
    logic [DATA_WIDTH-1:0] init_dataB;

    logic                  enc_ena;
    logic                  enc_finished;
    logic [ADDR_WIDTH-1:0] enc_memIn_addr;
    logic [ADDR_WIDTH-1:0] enc_memOut_addr;
    logic                  enc_wr_ena;
    logic [DATA_WIDTH-1:0] enc_data_out;

    logic                  dec_ena;
    logic                  dec_finished;
    logic [ADDR_WIDTH-1:0] dec_memIn_addr;
    logic [ADDR_WIDTH-1:0] dec_memOut_addr;
    logic                  dec_wr_ena;
    logic [DATA_WIDTH-1:0] dec_data_out;

    logic [ADDR_WIDTH-1:0] addrA;
    logic [ADDR_WIDTH-1:0] addrB;
    logic                  wr_enaA;
    logic                  wr_enaB;
    logic [DATA_WIDTH-1:0] ram_inA;
    logic [DATA_WIDTH-1:0] ram_inB;

    modport slave (
        input  start, init_finished, init_addrA, init_addrB, init_wr_enaA, init_wr_enaB,
               init_dataA, init_dataB, enc_finished, enc_memIn_addr, enc_memOut_addr,
               enc_wr_ena, enc_data_out, dec_finished, dec_memIn_addr, dec_memOut_addr,
               dec_wr_ena, dec_data_out,
        output busy, done, timeout_err, phase, init_ena, enc_ena, dec_ena,
               addrA, addrB, wr_enaA, wr_enaB, ram_inA, ram_inB
    );

    modport master (
        output start, init_finished, init_addrA, init_addrB, init_wr_enaA, init_wr_enaB,
               init_dataA, init_dataB, enc_finished, enc_memIn_addr, enc_memOut_addr,
               enc_wr_ena, enc_data_out, dec_finished, dec_memIn_addr, dec_memOut_addr,
               dec_wr_ena, dec_data_out,
        input  busy, done, timeout_err, phase, init_ena, enc_ena, dec_ena,
               addrA, addrB, wr_enaA, wr_enaB, ram_inA, ram_inB
    );

endinterface

// File: rtl/aes_ram_sequencer_watchdog.sv
// Per-phase watchdog: counts while enabled, clears on phase change, flags the last allowed cycle.
module aes_phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam logic [CNT_WIDTH-1:0] LP_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_expire = i_enable && (r_cnt == LP_LIMIT);

endmodule

// File: rtl/aes_ram_sequencer.sv
// Runs init -> encrypt -> decrypt and hands the dual-port RAM to exactly one engine at a time.
module aes_ram_sequencer
    import aes_ram_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic               clk,
    input  logic               rst,
    aes_ram_sequencer_if.slave bus
);
    state_e r_state;
    state_e w_next;
    logic   w_expire;
    logic   w_clear;
    logic   r_init_ena;
    logic   r_enc_ena;
    logic   r_dec_ena;
    logic   r_busy;
    logic   r_done;
    logic   r_timeout_err;

    logic [ADDR_WIDTH-1:0] w_addrA;
    logic [ADDR_WIDTH-1:0] w_addrB;
    logic                  w_wr_enaA;
    logic                  w_wr_enaB;
    logic [DATA_WIDTH-1:0] w_ram_inA;
    logic [DATA_WIDTH-1:0] w_ram_inB;

    // The active phase's finished flag is checked before expiry so that a coincident finish wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: if (bus.start) w_next = ST_INIT;
            ST_INIT: begin
                if (bus.init_finished)  w_next = ST_H1;
                else if (w_expire)      w_next = ST_ERROR;
            end
            ST_H1:   w_next = ST_ENC;
            ST_ENC: begin
                if (bus.enc_finished)   w_next = ST_H2;
                else if (w_expire)      w_next = ST_ERROR;
            end
            ST_H2:   w_next = ST_DEC;
            ST_DEC: begin
                if (bus.dec_finished)   w_next = ST_DONE;
                else if (w_expire)      w_next = ST_ERROR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_clear = (w_next != r_state);

    aes_phase_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (is_engine_phase(r_state)),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_init_ena    <= 1'b0;
            r_enc_ena     <= 1'b0;
            r_dec_ena     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_init_ena    <= (w_next == ST_INIT);
            r_enc_ena     <= (w_next == ST_ENC);
            r_dec_ena     <= (w_next == ST_DEC);
            r_busy        <= is_busy_state(w_next);
            r_done        <= (w_next == ST_DONE);
            r_timeout_err <= (w_next == ST_ERROR);
        end
    end

    // Mux follows the state register directly so an async reset releases the RAM at once.
    always_comb begin
        w_addrA   = {ADDR_WIDTH{RAM_IDLE_BIT}};
        w_addrB   = {ADDR_WIDTH{RAM_IDLE_BIT}};
        w_wr_enaA = RAM_IDLE_BIT;
        w_wr_enaB = RAM_IDLE_BIT;
        w_ram_inA = {DATA_WIDTH{RAM_IDLE_BIT}};
        w_ram_inB = {DATA_WIDTH{RAM_IDLE_BIT}};
        case (r_state)
            ST_INIT: begin
                w_addrA   = bus.init_addrA;
                w_addrB   = bus.init_addrB;
                w_wr_enaA = bus.init_wr_enaA;
                w_wr_enaB = bus.init_wr_enaB;
                w_ram_inA = bus.init_dataA;
                w_ram_inB = bus.init_dataB;
            end
            ST_ENC: begin
                w_addrA   = bus.enc_memIn_addr;
                w_addrB   = bus.enc_memOut_addr;
                w_wr_enaB = bus.enc_wr_ena;
                w_ram_inB = bus.enc_data_out;
            end
            ST_DEC: begin
                w_addrA   = bus.dec_memIn_addr;
                w_addrB   = bus.dec_memOut_addr;
                w_wr_enaB = bus.dec_wr_ena;
                w_ram_inB = bus.dec_data_out;
            end
            default: ;
        endcase
    end

    assign bus.addrA       = w_addrA;
    assign bus.addrB       = w_addrB;
    assign bus.wr_enaA     = w_wr_enaA;
    assign bus.wr_enaB     = w_wr_enaB;
    assign bus.ram_inA     = w_ram_inA;
    assign bus.ram_inB     = w_ram_inB;
    assign bus.init_ena    = r_init_ena;
    assign bus.enc_ena     = r_enc_ena;
    assign bus.dec_ena     = r_dec_ena;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.phase       = r_state;

endmodule

// File: doc/aes_ram_sequencer.md
Name: aes_ram_sequencer

Overview:
- Sequences the AES flow: memory-init engine, then encryption engine, then decryption engine.
- Owns both ports of the shared dual-port RAM and multiplexes them to exactly one engine at a time, replacing wired-OR port sharing.
- Issues the per-engine enables, consumes the per-engine finished flags and guards each phase with a watchdog.
- Sits between the engines and the Ram instance at the top of the AES design.

Parameters:
ADDR_WIDTH, 8, RAM address width
DATA_WIDTH, 32, RAM word width
TIMEOUT_CYCLES, 4096, max cycles allowed per phase before abort
CNT_WIDTH, 16, watchdog counter width (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run; honoured only in IDLE, DONE or ERROR
init_ena  out  1  enable to memory-init engine
init_finished  in  1  init engine complete (level)
init_addrA, init_addrB  in  ADDR_WIDTH  init engine port A/B address
init_wr_enaA, init_wr_enaB  in  1  init engine port A/B write enable
init_dataA, init_dataB  in  DATA_WIDTH  init engine port A/B write data
enc_ena  out  1  encryption enable
enc_finished  in  1  encryption complete (level)
enc_memIn_addr  in  ADDR_WIDTH  encryption read address (port A)
enc_memOut_addr  in  ADDR_WIDTH  encryption write address (port B)
enc_wr_ena  in  1  encryption write enable (port B)
enc_data_out  in  DATA_WIDTH  encryption write data (port B)
dec_ena, dec_finished, dec_memIn_addr, dec_memOut_addr, dec_wr_ena, dec_data_out  as enc_*, for decryption
addrA, addrB  out  ADDR_WIDTH  to RAM
wr_enaA, wr_enaB  out  1  to RAM
ram_inA, ram_inB  out  DATA_WIDTH  to RAM
busy  out  1  run in progress
done  out  1  run completed successfully; held until next start
timeout_err  out  1  watchdog fired; held until next start
phase  out  3  current state encoding

Behaviour:
- Reset values: every output is 0; state is IDLE and the watchdog is 0.
- States and phase codes: IDLE=0, INIT=1, H1=2, ENC=3, H2=4, DEC=5, DONE=6, ERROR=7.
- IDLE/DONE/ERROR with start=1: next state INIT; done and timeout_err clear on the same edge.
- INIT with init_finished=1: go to H1. H1 always goes to ENC after 1 cycle.
- ENC with enc_finished=1: go to H2. H2 always goes to DEC after 1 cycle.
- DEC with dec_finished=1: go to DONE.
- Enables are registered and decoded from the next state:
  - init_ena=1 exactly in INIT, enc_ena=1 exactly in ENC, dec_ena=1 exactly in DEC.
  - The enable is high on the cycle after the entering edge and low on the cycle after the finishing edge.
- Only the active phase's finished flag is sampled; stale high flags from other engines are ignored.
- If a finished flag is already high on entry, the phase lasts exactly 1 cycle.
- RAM mux is combinational from the state register:
  - INIT: both ports driven from init_*.
  - ENC/DEC: port A gets addr=*_memIn_addr, wr_enaA=0, ram_inA=0; port B gets addr=*_memOut_addr, wr_enaB=*_wr_ena, ram_inB=*_data_out.
  - All other states: all RAM outputs are 0, so no writes.
- Watchdog:
  - Clears on every state change and counts each cycle in INIT/ENC/DEC.
  - When it reaches TIMEOUT_CYCLES-1 without the phase's finished flag: go to ERROR, drop all enables, set timeout_err=1.
  - If finished and timeout occur on the same cycle, finished wins.
- busy=1 in states 1-5. done=1 only in DONE; timeout_err=1 only in ERROR.
- start while busy is ignored.
- rst asserted mid-run forces IDLE immediately (asynchronous); enables and RAM write enables drop without waiting for a clock.

Decomposition:
- Shared package: state encodings (phase codes 0-7) and the idle RAM-port constant (all zeros).
- Natural sub-module: aes_phase_watchdog (counter, clear, enable, expire output), reused per phase.

Test Plan:
- Nominal run: reset, pulse start; init_finished after 10 cycles, enc 20, dec 20 -> phase sequence 1,2,3,4,5,6; each enable high exactly 10/20/20 cycles; done=1, busy=0.
- Mux routing:
  - In ENC with enc_memOut_addr=0x05, enc_wr_ena=1, enc_data_out=0xDEADBEEF -> addrB=0x05, wr_enaB=1, ram_inB=0xDEADBEEF.
  - dec_wr_ena=1 at the same time has no effect.
  - In H1 and H2, wr_enaA=wr_enaB=0.
- Stale flag: init_finished held high through the run -> ENC is not skipped; enc_ena is still asserted.
- Timeout: TIMEOUT_CYCLES=16, enc_finished never asserted -> ERROR after 16 ENC cycles; enc_ena=0, timeout_err=1, phase=7. A new start restarts at INIT and clears timeout_err.
- Start while busy: start pulse in DEC -> ignored, run completes normally. Finished coincident with watchdog expiry -> normal advance.
- Reset mid-ENC: assert rst between clock edges -> enc_ena, wr_enaB, busy and phase go to 0 immediately.
